// File: rtl/demux_arr.sv
// Registered 1:2 stream demultiplexer for N-element array beats.
// Each output channel is a one-entry holding register with valid/ready flow control.
module demux_arr #(
  parameter int WIDTH   = 2,
  parameter int N       = 2,
  parameter int COUNT_W = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [WIDTH-1:0]   I [N-1:0],
  input  logic               S,
  input  logic               I_valid,
  output logic               I_ready,
  output logic [WIDTH-1:0]   O0 [N-1:0],
  output logic               O0_valid,
  input  logic               O0_ready,
  output logic [WIDTH-1:0]   O1 [N-1:0],
  output logic               O1_valid,
  input  logic               O1_ready,
  output logic [COUNT_W-1:0] count0,
  output logic [COUNT_W-1:0] count1
);

  logic load0;
  logic load1;
  logic drain0;
  logic drain1;

  // Ready follows only the selected channel, so a stalled peer never blocks the other.
  always_comb begin
    I_ready = S ? (~O1_valid | O1_ready) : (~O0_valid | O0_ready);
  end

  assign load0  = I_valid & I_ready & ~S;
  assign load1  = I_valid & I_ready &  S;
  assign drain0 = O0_valid & O0_ready;
  assign drain1 = O1_valid & O1_ready;

  // Channel 0: a load wins over a drain, giving bubble-free drain-and-refill.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      O0_valid <= 1'b0;
      count0   <= '0;
      for (int j = 0; j < N; j++) O0[j] <= '0;
    end else begin
      if (load0) begin
        O0_valid <= 1'b1;
        for (int j = 0; j < N; j++) O0[j] <= I[j];
      end else if (drain0) begin
        O0_valid <= 1'b0;
      end
      if (drain0) count0 <= count0 + COUNT_W'(1);
    end
  end

  // Channel 1 mirrors channel 0 and drains independently of it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      O1_valid <= 1'b0;
      count1   <= '0;
      for (int j = 0; j < N; j++) O1[j] <= '0;
    end else begin
      if (load1) begin
        O1_valid <= 1'b1;
        for (int j = 0; j < N; j++) O1[j] <= I[j];
      end else if (drain1) begin
        O1_valid <= 1'b0;
      end
      if (drain1) count1 <= count1 + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_demux_arr.sv
// Directed self-checking bench for demux_arr: reset, routing, backpressure,
// streaming, counter wrap and reset while a beat is stalled.
module tb_demux_arr;

  localparam int WIDTH   = 4;
  localparam int N       = 2;
  localparam int COUNT_W = 8;

  logic               CLK = 1'b0;
  logic               RESET;
  logic [WIDTH-1:0]   I [N-1:0];
  logic               S;
  logic               I_valid;
  logic               I_ready;
  logic [WIDTH-1:0]   O0 [N-1:0];
  logic               O0_valid;
  logic               O0_ready;
  logic [WIDTH-1:0]   O1 [N-1:0];
  logic               O1_valid;
  logic               O1_ready;
  logic [COUNT_W-1:0] count0;
  logic [COUNT_W-1:0] count1;

  int num_compared = 0;
  int num_mismatched = 0;

  demux_arr #(.WIDTH(WIDTH), .N(N), .COUNT_W(COUNT_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .I(I), .S(S), .I_valid(I_valid), .I_ready(I_ready),
    .O0(O0), .O0_valid(O0_valid), .O0_ready(O0_ready),
    .O1(O1), .O1_valid(O1_valid), .O1_ready(O1_ready),
    .count0(count0), .count1(count1)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_compared++;
    if (observed !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] e1, input logic [WIDTH-1:0] e0,
                               input logic sel, input logic valid);
    I[1]    = e1;
    I[0]    = e0;
    S       = sel;
    I_valid = valid;
    #1;
  endtask

  // Advance past the next rising edge so registered outputs have settled.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyReset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    RESET    = 1'b1;
    O0_ready = 1'b1;
    O1_ready = 1'b1;
    applyStimulus(4'h3, 4'h2, 1'b0, 1'b1);
    tick();
    tick();
    RESET = 1'b0;
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("rst_o0_valid", O0_valid, 0);
    checkOutput("rst_o1_valid", O1_valid, 0);
    checkOutput("rst_count0", count0, 0);
    checkOutput("rst_count1", count1, 0);
    checkOutput("rst_o0_data", {O0[1], O0[0]}, 0);
    checkOutput("rst_o1_data", {O1[1], O1[0]}, 0);

    // Routing to channel 0 then channel 1
    applyStimulus(4'h2, 4'h1, 1'b0, 1'b1);
    checkOutput("route_ready0", I_ready, 1);
    tick();
    checkOutput("route_o0_valid", O0_valid, 1);
    checkOutput("route_o0_e1", O0[1], 4'h2);
    checkOutput("route_o0_e0", O0[0], 4'h1);
    checkOutput("route_o1_idle", O1_valid, 0);
    applyStimulus(4'h3, 4'h0, 1'b1, 1'b1);
    checkOutput("route_ready1", I_ready, 1);
    tick();
    checkOutput("route_o1_valid", O1_valid, 1);
    checkOutput("route_o1_data", {O1[1], O1[0]}, 8'h30);
    checkOutput("route_o0_drained", O0_valid, 0);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    checkOutput("route_count0", count0, 1);
    checkOutput("route_count1", count1, 1);
    checkOutput("route_o1_drained", O1_valid, 0);

    // Backpressure on channel 0 while channel 1 keeps accepting
    O0_ready = 1'b0;
    O1_ready = 1'b0;
    applyStimulus(4'h1, 4'h2, 1'b0, 1'b1);
    tick();
    checkOutput("bp_o0_holds_a", {O0_valid, O0[1], O0[0]}, 9'h112);
    applyStimulus(4'h7, 4'h6, 1'b0, 1'b1);
    checkOutput("bp_ready_blocked", I_ready, 0);
    tick();
    checkOutput("bp_o0_still_a", {O0_valid, O0[1], O0[0]}, 9'h112);
    checkOutput("bp_o1_idle", O1_valid, 0);
    applyStimulus(4'h7, 4'h6, 1'b1, 1'b1);
    checkOutput("bp_ready_other", I_ready, 1);
    tick();
    checkOutput("bp_o1_gets_b", {O1_valid, O1[1], O1[0]}, 9'h176);
    checkOutput("bp_o0_stalled", {O0_valid, O0[1], O0[0]}, 9'h112);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    O0_ready = 1'b1;
    O1_ready = 1'b1;
    tick();
    checkOutput("bp_count0", count0, 2);
    checkOutput("bp_count1", count1, 2);
    checkOutput("bp_both_empty", {O0_valid, O1_valid}, 0);

    // Streaming: ten back-to-back beats on channel 0
    applyReset();
    for (int k = 0; k < 10; k++) begin
      applyStimulus(4'h0, WIDTH'(k), 1'b0, 1'b1);
      checkOutput("stream_ready", I_ready, 1);
      tick();
      checkOutput("stream_valid", O0_valid, 1);
      checkOutput("stream_data", O0[0], k);
    end
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    checkOutput("stream_count0", count0, 10);
    checkOutput("stream_empty", O0_valid, 0);

    // Counter wrap: 256 handshakes on channel 1
    for (int k = 0; k < 256; k++) begin
      applyStimulus(4'h5, WIDTH'(k), 1'b1, 1'b1);
      checkOutput("wrap_ready", I_ready, 1);
      tick();
    end
    checkOutput("wrap_count1_255", count1, 255);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    checkOutput("wrap_count1_0", count1, 0);
    checkOutput("wrap_count0_same", count0, 10);

    // Reset while channel 1 holds a stalled beat
    O1_ready = 1'b0;
    applyStimulus(4'h9, 4'h8, 1'b1, 1'b1);
    tick();
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("midrst_o1_full", O1_valid, 1);
    O1_ready = 1'b1;
    RESET    = 1'b1;
    tick();
    RESET = 1'b0;
    checkOutput("midrst_o1_valid", O1_valid, 0);
    checkOutput("midrst_count1", count1, 0);
    checkOutput("midrst_o1_data", {O1[1], O1[0]}, 0);
    tick();
    checkOutput("midrst_count1_after", count1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule

// File: doc/demux_arr.md
Name: demux_arr

Overview:
- Registered 1:2 stream demultiplexer for array-of-Bits payloads; the inverse of the 2:1 array mux.
- Accepts one N-element array beat per handshake and steers it, by a select bit captured with the beat, into one of two output channels.
- Each output channel has a one-entry holding register and valid/ready flow control.
- Sits downstream of array producers that fan out to two consumers.

Parameters:
WIDTH, 2, bit width of each array element
N, 2, number of array elements per beat
COUNT_W, 8, width of per-output delivered-beat counters

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
I  input  [WIDTH-1:0] x [N-1:0]  input array beat (unpacked array of Bits)
S  input  1  destination select, qualified by I_valid: 0 selects O0, 1 selects O1
I_valid  input  1  input beat valid
I_ready  output  1  block can accept the input beat this cycle
O0  output  [WIDTH-1:0] x [N-1:0]  channel 0 array data
O0_valid  output  1  channel 0 holds a beat
O0_ready  input  1  channel 0 consumer accepts
O1  output  [WIDTH-1:0] x [N-1:0]  channel 1 array data
O1_valid  output  1  channel 1 holds a beat
O1_ready  input  1  channel 1 consumer accepts
count0  output  COUNT_W  beats delivered on channel 0
count1  output  COUNT_W  beats delivered on channel 1

Behaviour:
- Reset (RESET=1 at a rising edge):
  - O0_valid, O1_valid = 0; O0, O1 = all zeros; count0, count1 = 0.
  - Takes priority over every other event; held beats are discarded.
- Input transfer occurs when I_valid & I_ready.
- I_ready is combinational:
  - S=0: I_ready = ~O0_valid | O0_ready.
  - S=1: I_ready = ~O1_valid | O1_ready.
  - I_ready must not depend on I_valid.
  - I_ready may change with S; a producer must hold S stable while I_valid=1.
- Latency: beat accepted in cycle t appears on Ok with Ok_valid=1 in cycle t+1. No combinational path from I to Ok.
- Element mapping is positional: Ok[j] = I[j] for j in 0..N-1. No reordering or packing is visible at the ports.
- Per-channel state k (holding register, two states):
  - EMPTY -> FULL on input transfer with S=k.
  - FULL -> EMPTY on Ok_ready with no load this cycle.
  - FULL -> FULL with new data on simultaneous drain and load. Old beat is delivered, new beat is registered, Ok_valid stays 1, no bubble.
- While Ok_valid=1 and Ok_ready=0, Ok data holds stable.
- Data in an EMPTY register retains its last value; consumers must not sample it.
- The unselected channel is unaffected by an input transfer and keeps draining independently. Both channels may drain in the same cycle.
- countk increments by 1 on each Ok_valid & Ok_ready. It wraps modulo 2^COUNT_W (255 -> 0 at the default width).

Test Plan:
- Reset: RESET=1 for 2 cycles with I_valid=1 -> O0_valid=O1_valid=0, count0=count1=0, O0=O1=0 after release.
- Routing: I={2'b10,2'b01}, S=0, I_valid=1, both readies=1 -> next cycle O0_valid=1, O0[1]=2'b10, O0[0]=2'b01, O1_valid=0. Next beat with S=1 appears only on O1. count0=1 and count1=1 after the drains.
- Backpressure:
  - O0_ready=0, send beat A with S=0 -> O0 holds A.
  - Second beat with S=0 -> I_ready=0, O0 still A.
  - Same beat with S=1 -> I_ready=1, delivered on O1 while O0 stalls.
- Streaming: O0_ready=1 constantly, 10 back-to-back S=0 beats of values 0..9 on element 0 -> I_ready=1 every cycle, O0_valid=1 from cycle 1 through 10, in-order delivery, count0=10.
- Wrap: 256 handshakes on channel 1 with COUNT_W=8 -> count1 returns to 0.
- Reset mid-operation: O1 FULL and stalled, assert RESET one cycle -> O1_valid=0 next cycle, the beat is never delivered, count1=0.
